// File: rtl/dmem_responder_if.sv
// Request/response bus between the datapath and the data memory responder.
// master = datapath side, slave = memory side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, MemRead, MemWrite,
    output addr, wdata, resp_ready,
    input  req_ready, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid, MemRead, MemWrite,
    input  addr, wdata, resp_ready,
    output req_ready, resp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed response latency and fault checks.
// One request in flight; response held until the datapath takes it.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic        clk,
  input logic        reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          rd_q, wr_q, flt_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          accept;
  logic          enter_resp;
  logic          flt;

  assign accept = (state == IDLE) && bus.req_valid
               && (bus.MemRead || bus.MemWrite);

  assign flt = (bus.addr[1:0] != 2'b00)
            || (bus.addr[31:AW+2] != '0)
            || (bus.MemRead && bus.MemWrite);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // WAIT always lasts LATENCY cycles so RESP lands LATENCY edges after accept
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    enter_resp     = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      flt_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rd_q    <= bus.MemRead;
      wr_q    <= bus.MemWrite;
      flt_q   <= flt;
      idx_q   <= bus.addr[AW+1:2];
      wdata_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && wr_q && !flt_q)
      mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= flt_q;
      rdata_q <= (rd_q && !flt_q) ? mem[idx_q] : '0;
    end else if (state == RESP && bus.resp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
endmodule
